// File: rtl/qs_srt_pkg.sv
// Shared qs_srt instruction-word layout and opcode set.
package qs_srt_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        JCC   = 4'd1,
        PP    = 4'd2,
        MEM   = 4'd3,
        MOV   = 4'd4,
        ARITH = 4'd5,
        CRET  = 4'd6,
        CNTRL = 4'd7
    } opcode_e;

    typedef struct packed {
        opcode_e     opcode;
        logic [3:0]  cond;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [15:0] imm;
    } inst_t;

endpackage

// File: rtl/qs_srt_prog_loader_if.sv
// Host-config, word-stream and imem-write bundle of the program loader.
interface qs_srt_prog_loader_if #(
    parameter int ADDR_W = 8
);
    import qs_srt_pkg::*;

    logic                     cfg_start;
    logic [ADDR_W-1:0]        cfg_base;
    logic [ADDR_W:0]          cfg_len;
    logic                     in_vld;
    inst_t                    in_inst;
    logic                     in_rdy;
    logic                     imem_wr_en;
    logic [ADDR_W-1:0]        imem_wr_addr;
    inst_t                    imem_wr_data;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [ADDR_W-1:0]        err_addr;
    logic [ADDR_W:0]          wr_cnt;
    logic [$bits(inst_t)-1:0] csum;

    modport master (
        output cfg_start, cfg_base, cfg_len, in_vld, in_inst,
        input  in_rdy, imem_wr_en, imem_wr_addr, imem_wr_data,
               busy, done, err, err_addr, wr_cnt, csum
    );

    modport slave (
        input  cfg_start, cfg_base, cfg_len, in_vld, in_inst,
        output in_rdy, imem_wr_en, imem_wr_addr, imem_wr_data,
               busy, done, err, err_addr, wr_cnt, csum
    );

endinterface

// File: rtl/qs_srt_prog_loader.sv
// Streams host instruction words into imem, rejecting illegal opcodes and
// tracking progress and an XOR checksum of everything committed.
module qs_srt_prog_loader
    import qs_srt_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int INST_W = $bits(qs_srt_pkg::inst_t)
) (
    input  logic                  clk,
    input  logic                  rst,
    qs_srt_prog_loader_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_e;

    state_e              state_q, state_d;
    logic                in_rdy_q, in_rdy_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    inst_t               wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
    logic [INST_W-1:0]   csum_q, csum_d;

    logic hs;
    logic op_legal;
    logic start_ok;
    logic last_word;

    assign hs        = in_rdy_q & bus.in_vld;
    assign start_ok  = bus.cfg_start & (state_q != S_LOAD);
    assign last_word = (rem_q == (ADDR_W + 1)'(1));

    always_comb begin
        op_legal = 1'b0;
        case (bus.in_inst.opcode)
            NOP, JCC, PP, MEM, MOV, ARITH, CRET, CNTRL: op_legal = 1'b1;
            default:                                    op_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cfg_start is ignored while a session is loading
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (hs) begin
                    if (!op_legal) begin
                        state_d = S_ERROR;
                    end else if (last_word) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                if (bus.cfg_start) begin
                    state_d = (bus.cfg_len == '0) ? S_DONE : S_LOAD;
                end
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        in_rdy_d   = (state_d == S_LOAD);
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        done_d     = done_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        wr_cnt_d   = wr_cnt_q;
        csum_d     = csum_q;

        if (start_ok) begin
            ptr_d      = bus.cfg_base;
            rem_d      = bus.cfg_len;
            done_d     = (bus.cfg_len == '0);
            err_d      = 1'b0;
            err_addr_d = '0;
            wr_cnt_d   = '0;
            csum_d     = '0;
        end else if (hs) begin
            if (op_legal) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = bus.in_inst;
                ptr_d     = ptr_q + ADDR_W'(1);
                rem_d     = rem_q - (ADDR_W + 1)'(1);
                wr_cnt_d  = wr_cnt_q + (ADDR_W + 1)'(1);
                csum_d    = csum_q ^ INST_W'(bus.in_inst);
                done_d    = last_word;
            end else begin
                err_d      = 1'b1;
                err_addr_d = ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_rdy_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            wr_cnt_q   <= '0;
            csum_q     <= '0;
        end else begin
            in_rdy_q   <= in_rdy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            wr_cnt_q   <= wr_cnt_d;
            csum_q     <= csum_d;
        end
    end

    assign bus.in_rdy       = in_rdy_q;
    assign bus.imem_wr_en   = wr_en_q;
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_wr_data = wr_data_q;
    assign bus.busy         = (state_q == S_LOAD);
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.err_addr     = err_addr_q;
    assign bus.wr_cnt       = wr_cnt_q;
    assign bus.csum         = csum_q;

endmodule

// File: tb/tb_qs_srt_prog_loader.sv
// Scenario bench for qs_srt_prog_loader: expected imem writes are queued as
// words are driven and matched against each observed write strobe.
module tb_qs_srt_prog_loader;
    import qs_srt_pkg::*;

    localparam int AW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   n_wr;
    wr_t  exp_q[$];

    qs_srt_prog_loader_if #(.ADDR_W(AW)) bus ();

    qs_srt_prog_loader #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic inst_t mk(opcode_e op);
        inst_t w;
        w = inst_t'($urandom);
        w.opcode = op;
        return w;
    endfunction

    // One clock; any write strobe seen is matched against the scoreboard
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (bus.imem_wr_en === 1'b1) begin
            n_wr++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL write_unexpected: got write addr=%h data=%h, required no write",
                         bus.imem_wr_addr, bus.imem_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.imem_wr_addr !== e.addr || bus.imem_wr_data !== e.data) begin
                    n_bad++;
                    $display("FAIL write_match: got addr=%h data=%h, required addr=%h data=%h",
                             bus.imem_wr_addr, bus.imem_wr_data, e.addr, e.data);
                end else begin
                    $display("write addr=%h data=%h", bus.imem_wr_addr, bus.imem_wr_data);
                end
            end
        end
    endtask

    task automatic start(input logic [AW-1:0] base, input logic [AW:0] len);
        bus.cfg_base  = base;
        bus.cfg_len   = len;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input inst_t w);
        wr_t e;
        e.addr = a;
        e.data = w;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.in_rdy !== 1'b0)     begin n_bad++; $display("FAIL reset_in_rdy: got %b required 0", bus.in_rdy); end
        n_cmp++; if (bus.imem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b required 0", bus.imem_wr_en); end
        n_cmp++; if (bus.busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b required 0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0)        begin n_bad++; $display("FAIL reset_err: got %b required 0", bus.err); end
        n_cmp++; if (bus.err_addr !== '0)     begin n_bad++; $display("FAIL reset_err_addr: got %h required 0", bus.err_addr); end
        n_cmp++; if (bus.wr_cnt !== '0)       begin n_bad++; $display("FAIL reset_wr_cnt: got %0d required 0", bus.wr_cnt); end
        n_cmp++; if (bus.csum !== '0)         begin n_bad++; $display("FAIL reset_csum: got %h required 0", bus.csum); end
    endtask

    task automatic test_basic();
        inst_t w[3];
        logic [31:0] cs;
        int wr0;
        w[0] = mk(NOP);
        w[1] = mk(MOV);
        w[2] = mk(CNTRL);
        cs = w[0] ^ w[1] ^ w[2];
        wr0 = n_wr;
        start(8'h10, 9'd3);
        n_cmp++; if (bus.in_rdy !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_start: got rdy=%b busy=%b required 1 1", bus.in_rdy, bus.busy); end
        for (int i = 0; i < 3; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_inst = w[i];
            push_exp(AW'(8'h10 + i), w[i]);
            tick();
            n_cmp++; if (bus.imem_wr_en !== 1'b1) begin n_bad++; $display("FAIL basic_wr_timing: word %0d got wr_en=%b required 1", i, bus.imem_wr_en); end
            n_cmp++; if (bus.done !== (i == 2)) begin n_bad++; $display("FAIL basic_done: word %0d got done=%b required %b", i, bus.done, (i == 2)); end
        end
        bus.in_vld = 1'b0;
        n_cmp++; if (bus.in_rdy !== 1'b0)  begin n_bad++; $display("FAIL basic_rdy_drop: got %b required 0", bus.in_rdy); end
        n_cmp++; if (bus.wr_cnt !== 9'd3)  begin n_bad++; $display("FAIL basic_wr_cnt: got %0d required 3", bus.wr_cnt); end
        n_cmp++; if (bus.csum !== cs)      begin n_bad++; $display("FAIL basic_csum: got %h required %h", bus.csum, cs); end
        tick();
        n_cmp++; if (n_wr - wr0 != 3)      begin n_bad++; $display("FAIL basic_nwrites: got %0d required 3", n_wr - wr0); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] addrs[4];
        inst_t w;
        addrs[0] = 8'hFE; addrs[1] = 8'hFF; addrs[2] = 8'h00; addrs[3] = 8'h01;
        start(8'hFE, 9'd4);
        for (int i = 0; i < 4; i++) begin
            w = mk(opcode_e'(4'(i + 1)));
            bus.in_vld  = 1'b1;
            bus.in_inst = w;
            push_exp(addrs[i], w);
            tick();
        end
        bus.in_vld = 1'b0;
        n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL wrap_done: got done=%b err=%b required 1 0", bus.done, bus.err); end
        n_cmp++; if (bus.wr_cnt !== 9'd4) begin n_bad++; $display("FAIL wrap_wr_cnt: got %0d required 4", bus.wr_cnt); end
        tick();
    endtask

    task automatic test_illegal();
        inst_t w[4];
        int wr0;
        w[0] = mk(PP);
        w[1] = mk(ARITH);
        w[2] = mk(NOP);
        w[2].opcode = opcode_e'(4'hB);
        w[3] = mk(MEM);
        start(8'h40, 9'd4);
        for (int i = 0; i < 3; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_inst = w[i];
            if (i < 2) push_exp(AW'(8'h40 + i), w[i]);
            tick();
        end
        n_cmp++; if (bus.err !== 1'b1)       begin n_bad++; $display("FAIL illegal_err: got %b required 1", bus.err); end
        n_cmp++; if (bus.err_addr !== 8'h42) begin n_bad++; $display("FAIL illegal_err_addr: got %h required 42", bus.err_addr); end
        n_cmp++; if (bus.wr_cnt !== 9'd2)    begin n_bad++; $display("FAIL illegal_wr_cnt: got %0d required 2", bus.wr_cnt); end
        n_cmp++; if (bus.done !== 1'b0)      begin n_bad++; $display("FAIL illegal_done: got %b required 0", bus.done); end
        n_cmp++; if (bus.in_rdy !== 1'b0)    begin n_bad++; $display("FAIL illegal_in_rdy: got %b required 0", bus.in_rdy); end
        n_cmp++; if (bus.csum !== (w[0] ^ w[1])) begin n_bad++; $display("FAIL illegal_csum: got %h required %h", bus.csum, w[0] ^ w[1]); end
        wr0 = n_wr;
        bus.in_inst = w[3];
        for (int i = 0; i < 3; i++) tick();
        bus.in_vld = 1'b0;
        n_cmp++; if (n_wr != wr0)            begin n_bad++; $display("FAIL illegal_no_more_writes: got %0d writes required 0", n_wr - wr0); end
        n_cmp++; if (bus.err !== 1'b1)       begin n_bad++; $display("FAIL illegal_err_sticky: got %b required 1", bus.err); end
    endtask

    task automatic test_backpressure();
        logic [5:0] pat;
        inst_t w;
        int k;
        int wr0;
        pat = 6'b101001;
        k = 0;
        wr0 = n_wr;
        start(8'h80, 9'd3);
        for (int i = 0; i < 6; i++) begin
            bus.in_vld = pat[i];
            if (pat[i]) begin
                w = mk(CRET);
                bus.in_inst = w;
                push_exp(AW'(8'h80 + k), w);
                k++;
            end
            tick();
            n_cmp++; if (bus.imem_wr_en !== pat[i]) begin n_bad++; $display("FAIL bp_wr_timing: cycle %0d got wr_en=%b required %b", i, bus.imem_wr_en, pat[i]); end
        end
        bus.in_vld = 1'b0;
        n_cmp++; if (bus.done !== 1'b1)   begin n_bad++; $display("FAIL bp_done: got %b required 1", bus.done); end
        n_cmp++; if (bus.wr_cnt !== 9'd3) begin n_bad++; $display("FAIL bp_wr_cnt: got %0d required 3", bus.wr_cnt); end
        tick();
        n_cmp++; if (n_wr - wr0 != 3)     begin n_bad++; $display("FAIL bp_nwrites: got %0d required 3", n_wr - wr0); end
    endtask

    task automatic test_zero_restart();
        inst_t w;
        int wr0;
        wr0 = n_wr;
        start(8'h20, 9'd0);
        n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL zero_done: got done=%b busy=%b err=%b required 1 0 0", bus.done, bus.busy, bus.err); end
        tick();
        n_cmp++; if (n_wr != wr0) begin n_bad++; $display("FAIL zero_no_write: got %0d writes required 0", n_wr - wr0); end
        start(8'h30, 9'd1);
        n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL restart_state: got done=%b busy=%b required 0 1", bus.done, bus.busy); end
        start(8'h99, 9'd0);
        n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.in_rdy !== 1'b1) begin n_bad++; $display("FAIL start_in_load_ignored: got busy=%b done=%b rdy=%b required 1 0 1", bus.busy, bus.done, bus.in_rdy); end
        w = mk(JCC);
        bus.in_vld  = 1'b1;
        bus.in_inst = w;
        push_exp(8'h30, w);
        tick();
        bus.in_vld = 1'b0;
        n_cmp++; if (bus.done !== 1'b1)   begin n_bad++; $display("FAIL restart_done: got %b required 1", bus.done); end
        n_cmp++; if (bus.wr_cnt !== 9'd1) begin n_bad++; $display("FAIL restart_wr_cnt: got %0d required 1", bus.wr_cnt); end
        n_cmp++; if (bus.csum !== w)      begin n_bad++; $display("FAIL restart_csum: got %h required %h", bus.csum, w); end
        tick();
    endtask

    task automatic test_reset_mid();
        inst_t w;
        int wr0;
        start(8'h50, 9'd5);
        w = mk(MOV);
        bus.in_vld  = 1'b1;
        bus.in_inst = w;
        push_exp(8'h50, w);
        tick();
        rst = 1'b1;
        bus.in_inst = mk(MOV);
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.imem_wr_en !== 1'b0 || bus.in_rdy !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl: got wr_en=%b rdy=%b busy=%b required 0 0 0", bus.imem_wr_en, bus.in_rdy, bus.busy); end
        n_cmp++; if (bus.wr_cnt !== '0 || bus.csum !== '0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_status: got wr_cnt=%0d csum=%h done=%b required 0 0 0", bus.wr_cnt, bus.csum, bus.done); end
        wr0 = n_wr;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.in_rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid_rdy: cycle %0d got %b required 0", i, bus.in_rdy); end
        end
        bus.in_vld = 1'b0;
        n_cmp++; if (n_wr != wr0) begin n_bad++; $display("FAIL rstmid_no_write: got %0d writes required 0", n_wr - wr0); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_wr  = 0;
        rst           = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_base  = '0;
        bus.cfg_len   = '0;
        bus.in_vld    = 1'b0;
        bus.in_inst   = '0;

        test_reset();
        test_basic();
        test_wrap();
        test_illegal();
        test_backpressure();
        test_zero_restart();
        test_reset_mid();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending writes required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
